// File: rtl/vending_pkg.sv
// Shared definitions for the coin change dispenser: FSM state encoding and coin values.
package vending_pkg;

  // Dispenser FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_PULSE  = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int unsigned COIN_TEN  = 10;
  localparam int unsigned COIN_FIVE = 5;

endpackage

// File: rtl/coin_change_dispenser_if.sv
// Request/result bus between a change requester and the coin change dispenser.
//   master: drives req_valid/req_amount, observes req_ready/done/short/remaining
//   slave : the dispenser side
interface coin_change_dispenser_if #(
  parameter int unsigned AMT_W = 7
);
  logic             req_valid;
  logic             req_ready;
  logic [AMT_W-1:0] req_amount;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remaining;

  modport master (output req_valid, req_amount, input req_ready, done, short, remaining);
  modport slave  (input req_valid, req_amount, output req_ready, done, short, remaining);
endinterface

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter that times both the coin pulse and the gap after it.
//   clock, reset_n : clock, async active-low reset
//   load           : restart the count with value (value = cycles - 1)
//   value          : reload value
//   expire         : registered, high in the last cycle of the loaded interval
module coin_pulse_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expire;

  // Count down to zero; expire is flagged one cycle ahead so it lines up with the last cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (load) begin
      r_cnt    <= value;
      r_expire <= (value == '0);
    end else if (r_cnt != '0) begin
      r_cnt    <= r_cnt - CNT_W'(1);
      r_expire <= (r_cnt == CNT_W'(1));
    end
  end

  assign expire = r_expire;

endmodule

// File: rtl/coin_change_dispenser.sv
// Coin change dispenser: accepts a rupee amount, pays it greedily in ten/five coins as paced
// ejector pulses, tracks hopper stock and reports any unpaid remainder.
//   clock, reset_n               : clock, async active-low reset
//   bus (slave)                  : req_valid/req_ready/req_amount in, done/short/remaining out
//   refill_ten, refill_five      : one coin added to the respective hopper this cycle
//   abort                        : only with CHANGE_DISPENSER_ABORT_EN defined; stop after current coin
//   rupee_ten_out, rupee_five_out: ejector drives
//   ten_stock, five_stock        : current hopper counts
module coin_change_dispenser
  import vending_pkg::*;
#(
  parameter int unsigned AMT_W     = 7,
  parameter int unsigned STOCK_W   = 5,
  parameter int unsigned TEN_INIT  = 8,
  parameter int unsigned FIVE_INIT = 8,
  parameter int unsigned PULSE_CYC = 4,
  parameter int unsigned GAP_CYC   = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  coin_change_dispenser_if.slave bus,
  input  logic               refill_ten,
  input  logic               refill_five,
`ifdef CHANGE_DISPENSER_ABORT_EN
  input  logic               abort,
`endif
  output logic               rupee_ten_out,
  output logic               rupee_five_out,
  output logic [STOCK_W-1:0] ten_stock,
  output logic [STOCK_W-1:0] five_stock
);

  localparam int unsigned TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_t             r_state, w_state_nxt;
  logic [AMT_W-1:0]   r_rem;
  logic               r_sel_ten;
  logic               r_ready, r_done, r_short, r_ten_out, r_five_out;
  logic [AMT_W-1:0]   r_remaining;
  logic [STOCK_W-1:0] r_ten_stock, r_five_stock;

  logic             w_accept, w_can_ten, w_can_five, w_expire, w_abort;
  logic             w_sel_ten_nxt, w_ten_out_nxt, w_five_out_nxt;
  logic             w_tmr_load, w_dec_ten, w_dec_five, w_pick;
  logic [TMR_W-1:0] w_tmr_value;

  assign w_accept   = bus.req_valid && r_ready;
  assign w_can_ten  = (r_rem >= AMT_W'(COIN_TEN))  && (r_ten_stock  != '0);
  assign w_can_five = (r_rem >= AMT_W'(COIN_FIVE)) && (r_five_stock != '0);

`ifdef CHANGE_DISPENSER_ABORT_EN
  logic r_abort;

  // Remember an abort seen mid-coin so the dispense ends after the current gap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                                  r_abort <= 1'b0;
    else if (w_accept)                                             r_abort <= 1'b0;
    else if (abort && (r_state == ST_PULSE || r_state == ST_GAP))  r_abort <= 1'b1;
  end

  assign w_abort = abort || r_abort;
`else
  assign w_abort = 1'b0;
`endif

  coin_pulse_timer #(.CNT_W(TMR_W)) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (w_tmr_load),
    .value   (w_tmr_value),
    .expire  (w_expire)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SELECT;
      ST_SELECT: begin
        if (w_abort)                      w_state_nxt = ST_DONE;
        else if (w_can_ten || w_can_five) w_state_nxt = ST_PULSE;
        else                              w_state_nxt = ST_DONE;
      end
      ST_PULSE:  if (w_expire) w_state_nxt = ST_GAP;
      ST_GAP:    if (w_expire) w_state_nxt = w_abort ? ST_DONE : ST_SELECT;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath decode: next values of the registered outputs, timer and stock controls
  always_comb begin
    w_sel_ten_nxt  = r_sel_ten;
    w_pick         = 1'b0;
    w_tmr_load     = 1'b0;
    w_tmr_value    = TMR_W'(PULSE_CYC - 1);
    if (r_state == ST_SELECT) begin
      w_sel_ten_nxt = w_can_ten;
      w_pick        = (w_state_nxt == ST_PULSE);
      w_tmr_load    = w_pick;
    end else if (r_state == ST_PULSE && w_expire) begin
      w_tmr_load  = 1'b1;
      w_tmr_value = TMR_W'(GAP_CYC - 1);
    end
    w_dec_ten      = w_pick && w_sel_ten_nxt;
    w_dec_five     = w_pick && !w_sel_ten_nxt;
    w_ten_out_nxt  = (w_state_nxt == ST_PULSE) && w_sel_ten_nxt;
    w_five_out_nxt = (w_state_nxt == ST_PULSE) && !w_sel_ten_nxt;
  end

  // Saturating hopper update; a simultaneous refill and payout cancel out
  function automatic logic [STOCK_W-1:0] stock_nxt(input logic [STOCK_W-1:0] s,
                                                   input logic inc, input logic dec);
    logic [STOCK_W-1:0] n;
    n = s;
    if (inc && !dec && (s != '1)) n = s + STOCK_W'(1);
    else if (dec && !inc)         n = s - STOCK_W'(1);
    return n;
  endfunction

  // Registered outputs, remainder and stock counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rem        <= '0;
      r_sel_ten    <= 1'b0;
      r_ready      <= 1'b1;
      r_done       <= 1'b0;
      r_short      <= 1'b0;
      r_remaining  <= '0;
      r_ten_out    <= 1'b0;
      r_five_out   <= 1'b0;
      r_ten_stock  <= STOCK_W'(TEN_INIT);
      r_five_stock <= STOCK_W'(FIVE_INIT);
    end else begin
      r_sel_ten    <= w_sel_ten_nxt;
      r_ready      <= (w_state_nxt == ST_IDLE);
      r_done       <= (w_state_nxt == ST_DONE);
      r_ten_out    <= w_ten_out_nxt;
      r_five_out   <= w_five_out_nxt;
      r_ten_stock  <= stock_nxt(r_ten_stock, refill_ten, w_dec_ten);
      r_five_stock <= stock_nxt(r_five_stock, refill_five, w_dec_five);
      if (w_accept) begin
        r_rem       <= bus.req_amount;
        r_short     <= 1'b0;
        r_remaining <= '0;
      end else if (w_pick) begin
        r_rem <= r_rem - (w_sel_ten_nxt ? AMT_W'(COIN_TEN) : AMT_W'(COIN_FIVE));
      end
      if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
        r_remaining <= r_rem;
        r_short     <= (r_rem != '0);
      end
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.done       = r_done;
  assign bus.short      = r_short;
  assign bus.remaining  = r_remaining;
  assign rupee_ten_out  = r_ten_out;
  assign rupee_five_out = r_five_out;
  assign ten_stock      = r_ten_stock;
  assign five_stock     = r_five_stock;

endmodule
